// File: rtl/spdif_pkg.sv
// -----------------------------------------------------------------------------
// spdif_pkg
//   Shared definitions for the S/PDIF transmit scheduler:
//     SAMPLE_W       default audio sample width in bits
//     channel_e      subframe channel (CH_A = left, CH_B = right)
//     sched_state_e  scheduler FSM states
// -----------------------------------------------------------------------------
package spdif_pkg;

    localparam int SAMPLE_W = 20;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } channel_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN_A   = 2'd2,
        ST_RUN_B   = 2'd3
    } sched_state_e;

endpackage : spdif_pkg

// File: rtl/sched_fifo.sv
// -----------------------------------------------------------------------------
// sched_fifo
//   Single-clock FIFO holding one audio channel for the transmit scheduler.
//   A write to a full FIFO is dropped unless a pop happens in the same cycle,
//   in which case both take effect and the level is unchanged. flush empties
//   the FIFO and overrides any write or pop in the same cycle.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous empty request (highest priority)
//   wr_en        write request, wr_data is the sample
//   rd_en        pop request (ignored when empty)
//   rd_data      current head of the FIFO (combinational)
//   level        number of stored samples, 0..DEPTH
//   full, empty  level == DEPTH / level == 0
// -----------------------------------------------------------------------------
module sched_fifo #(
    parameter  int DW    = 20,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: the sample storage is deliberately not reset; pointers and level
    // define which entries are valid, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule : sched_fifo

// File: rtl/spdif_tx_scheduler.sv
// -----------------------------------------------------------------------------
// spdif_tx_scheduler
//   Buffers decoded left/right samples in two FIFOs and hands them to the
//   frame assembler in strict A,B,A,B order. Transmission starts once both
//   FIFOs hold PREFILL samples. A starved slot sends silence and pulses
//   underrun; a write to a full FIFO is dropped and pulses overflow. kill
//   flushes everything and returns to IDLE.
//
//   The sample for each slot is captured into tx_data when the slot starts,
//   so tx_data stays stable for the whole slot even if the FIFO is written
//   meanwhile. A slot captured from an empty FIFO stays silent until the
//   next frame_ready.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   sample_in       decoded sample, qualified by sample_valid
//   sample_channel  0 = channel A, 1 = channel B
//   kill            lock lost: flush both FIFOs, go to IDLE
//   frame_ready     frame assembler consumed tx_data
//   tx_data         sample of the current slot (0 = silence)
//   tx_valid        high in RUN_A / RUN_B
//   tx_channel      channel of the current slot
//   underrun        one-cycle pulse after a silent slot is consumed
//   overflow        one-cycle pulse after a write was dropped
//
// Optional (macro SPDIF_SCHED_STATS_EN)
//   underrun_cnt, overflow_cnt  saturating event counters, cleared by reset only
// -----------------------------------------------------------------------------
module spdif_tx_scheduler
    import spdif_pkg::*;
#(
    parameter int DW      = SAMPLE_W,
    parameter int DEPTH   = 8,
    parameter int PREFILL = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    input  logic          sample_channel,
    input  logic          kill,
    input  logic          frame_ready,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    output logic          tx_channel,
    output logic          underrun,
    output logic          overflow
`ifdef SPDIF_SCHED_STATS_EN
  , output logic [7:0]    underrun_cnt
  , output logic [7:0]    overflow_cnt
`endif
);

    localparam int            LW          = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);

    sched_state_e  state;
    sched_state_e  state_next;
    logic          load_slot;
    channel_e      load_ch;

    logic          slot_full;
    logic          wr_a, wr_b;
    logic          pop_a, pop_b;
    logic          underrun_d;
    logic          overflow_d;

    logic [DW-1:0] head_a, head_b;
    logic [LW-1:0] level_a, level_b;
    logic          full_a, full_b;
    logic          empty_a, empty_b;

    // ------------------------------------------------------------------
    // Channel FIFOs
    // ------------------------------------------------------------------
    assign wr_a = sample_valid && (sample_channel == CH_A) && !kill;
    assign wr_b = sample_valid && (sample_channel == CH_B) && !kill;

    // Only a slot that captured real data pops its FIFO.
    assign pop_a = (state == ST_RUN_A) && frame_ready && slot_full && !kill;
    assign pop_b = (state == ST_RUN_B) && frame_ready && slot_full && !kill;

    sched_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (kill),
        .wr_en   (wr_a),
        .wr_data (sample_in),
        .rd_en   (pop_a),
        .rd_data (head_a),
        .level   (level_a),
        .full    (full_a),
        .empty   (empty_a)
    );

    sched_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (kill),
        .wr_en   (wr_b),
        .wr_data (sample_in),
        .rd_en   (pop_b),
        .rd_data (head_b),
        .level   (level_b),
        .full    (full_b),
        .empty   (empty_b)
    );

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_next = state;
        load_slot  = 1'b0;
        load_ch    = CH_A;
        case (state)
            ST_IDLE: begin
                if (sample_valid) state_next = ST_PREFILL;
            end
            ST_PREFILL: begin
                if (level_a >= PREFILL_LVL && level_b >= PREFILL_LVL) begin
                    state_next = ST_RUN_A;
                    load_slot  = 1'b1;
                    load_ch    = CH_A;
                end
            end
            ST_RUN_A: begin
                if (frame_ready) begin
                    state_next = ST_RUN_B;
                    load_slot  = 1'b1;
                    load_ch    = CH_B;
                end
            end
            ST_RUN_B: begin
                if (frame_ready) begin
                    state_next = ST_RUN_A;
                    load_slot  = 1'b1;
                    load_ch    = CH_A;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // kill outranks every other event in the cycle.
        if (kill) begin
            state_next = ST_IDLE;
            load_slot  = 1'b0;
        end
    end

    assign tx_valid   = (state == ST_RUN_A) || (state == ST_RUN_B);
    assign tx_channel = (state == ST_RUN_B);

    // ------------------------------------------------------------------
    // Slot capture and event pulses
    // ------------------------------------------------------------------
    assign underrun_d = tx_valid && frame_ready && !slot_full && !kill;
    assign overflow_d = (wr_a && full_a && !pop_a) || (wr_b && full_b && !pop_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data   <= '0;
            slot_full <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            underrun <= underrun_d;
            overflow <= overflow_d;
            if (kill) begin
                tx_data   <= '0;
                slot_full <= 1'b0;
            end else if (load_slot) begin
                // The FIFO feeding the next slot is never popped in this
                // cycle, so its current head is the sample to present.
                if (load_ch == CH_A) begin
                    tx_data   <= empty_a ? '0 : head_a;
                    slot_full <= !empty_a;
                end else begin
                    tx_data   <= empty_b ? '0 : head_b;
                    slot_full <= !empty_b;
                end
            end
        end
    end

`ifdef SPDIF_SCHED_STATS_EN
    // Saturating statistics; kill does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
            overflow_cnt <= '0;
        end else begin
            if (underrun_d && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
            if (overflow_d && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
        end
    end
`endif

endmodule : spdif_tx_scheduler

// File: tb/tb_spdif_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spdif_tx_scheduler
//   Directed bench for spdif_tx_scheduler at DW=20, DEPTH=8, PREFILL=4.
//   Inputs change 1 ns after the rising edge and outputs are observed there.
//   Define SPDIF_SCHED_STATS_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spdif_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] sample_in;
    logic        sample_valid;
    logic        sample_channel;
    logic        kill;
    logic        frame_ready;
    logic [19:0] tx_data;
    logic        tx_valid;
    logic        tx_channel;
    logic        underrun;
    logic        overflow;
`ifdef SPDIF_SCHED_STATS_EN
    logic [7:0]  underrun_cnt;
    logic [7:0]  overflow_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    spdif_tx_scheduler #(.DW(20), .DEPTH(8), .PREFILL(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_channel (sample_channel),
        .kill           (kill),
        .frame_ready    (frame_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_channel     (tx_channel),
        .underrun       (underrun),
        .overflow       (overflow)
`ifdef SPDIF_SCHED_STATS_EN
      , .underrun_cnt   (underrun_cnt)
      , .overflow_cnt   (overflow_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sample(input logic ch, input logic [19:0] d);
        sample_valid   = 1'b1;
        sample_channel = ch;
        sample_in      = d;
        tick();
        sample_valid   = 1'b0;
    endtask

    task automatic frame();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    task automatic do_kill();
        kill = 1'b1;
        tick();
        kill = 1'b0;
    endtask

    task automatic check_slot(input string tag, input logic ch, input logic [19:0] d);
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_chan"},  32'(tx_channel), 32'(ch));
        check({tag, "_data"},  32'(tx_data), 32'(d));
    endtask

    initial begin
        logic [19:0] exp_d;
        logic        exp_ch;

        rst_n          = 1'b0;
        sample_in      = '0;
        sample_valid   = 1'b0;
        sample_channel = 1'b0;
        kill           = 1'b0;
        frame_ready    = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_tx_valid",   32'(tx_valid),   32'd0);
        check("rst_tx_data",    32'(tx_data),    32'd0);
        check("rst_tx_channel", 32'(tx_channel), 32'd0);
        check("rst_underrun",   32'(underrun),   32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        rst_n = 1'b1;

        // ---------------- prefill and basic A/B alternation ----------------
        for (int i = 1; i <= 4; i++) write_sample(1'b0, 20'(i));
        for (int i = 1; i <= 3; i++) begin
            write_sample(1'b1, 20'h10000 + 20'(i));
            check("prefill_no_valid", 32'(tx_valid), 32'd0);
        end
        frame();   // ignored while tx_valid is low
        check("prefill_frame_ignored_underrun", 32'(underrun), 32'd0);
        check("prefill_frame_ignored_level_a", 32'(dut.level_a), 32'd4);
        write_sample(1'b1, 20'h10004);
        check("prefill_after_b4_still_low", 32'(tx_valid), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            exp_ch = 1'(i % 2);
            exp_d  = exp_ch ? (20'h10000 + 20'(i / 2 + 1)) : 20'(i / 2 + 1);
            check_slot("seq", exp_ch, exp_d);
            repeat (7) tick();
            check("seq_hold", 32'(tx_data), 32'(exp_d));
            frame();
            check("seq_no_underrun", 32'(underrun), 32'd0);
        end
        // Both FIFOs drained: A slot is silent, consuming it pulses underrun.
        check_slot("drained_a", 1'b0, 20'h0);
        frame();
        check("drained_underrun", 32'(underrun), 32'd1);
        check("drained_chan", 32'(tx_channel), 32'd1);
        tick();
        check("drained_underrun_one_cycle", 32'(underrun), 32'd0);

        // ---------------- underrun on starved B slots ----------------
        do_kill();
        for (int i = 1; i <= 7; i++) write_sample(1'b0, 20'h00100 + 20'(i));
        for (int i = 1; i <= 4; i++) write_sample(1'b1, 20'h10100 + 20'(i));
        tick();
        for (int i = 0; i < 14; i++) begin
            exp_ch = 1'(i % 2);
            if (!exp_ch)      exp_d = 20'h00100 + 20'(i / 2 + 1);
            else if (i < 8)   exp_d = 20'h10100 + 20'(i / 2 + 1);
            else              exp_d = 20'h0;
            check_slot("starve", exp_ch, exp_d);
            frame();
            check("starve_underrun", 32'(underrun), (exp_ch && i >= 8) ? 32'd1 : 32'd0);
        end

        // ---------------- overflow on 9 writes into depth-8 FIFO ----------------
        do_kill();
        for (int i = 1; i <= 9; i++) begin
            write_sample(1'b0, 20'h00200 + 20'(i));
            check("ovf_pulse", 32'(overflow), (i == 9) ? 32'd1 : 32'd0);
        end
        tick();
        check("ovf_pulse_one_cycle", 32'(overflow), 32'd0);
        check("ovf_level_a", 32'(dut.level_a), 32'd8);
        for (int i = 1; i <= 8; i++) write_sample(1'b1, 20'h00300 + 20'(i));
        check("ovf_b_no_overflow", 32'(overflow), 32'd0);
        tick();
        check_slot("ovf_first", 1'b0, 20'h00201);
        // Pop A while writing A into the full FIFO: both happen.
        frame_ready    = 1'b1;
        sample_valid   = 1'b1;
        sample_channel = 1'b0;
        sample_in      = 20'h0020A;
        tick();
        frame_ready    = 1'b0;
        sample_valid   = 1'b0;
        check("full_wr_pop_no_overflow", 32'(overflow), 32'd0);
        check("full_wr_pop_level", 32'(dut.level_a), 32'd8);
        for (int j = 0; j < 16; j++) begin
            exp_ch = (j % 2 == 1) ? 1'b0 : 1'b1;
            if (exp_ch)        exp_d = 20'h00301 + 20'(j / 2);
            else if (j < 15)   exp_d = 20'h00202 + 20'((j - 1) / 2);
            else               exp_d = 20'h0020A;
            check_slot("ovf_pop", exp_ch, exp_d);
            frame();
        end

        // ---------------- kill with simultaneous write and frame_ready ----------------
        write_sample(1'b0, 20'h00AAA);
        write_sample(1'b1, 20'h00BBB);
        write_sample(1'b0, 20'h00AAB);
        kill           = 1'b1;
        sample_valid   = 1'b1;
        sample_channel = 1'b0;
        sample_in      = 20'h00CCC;
        frame_ready    = 1'b1;
        tick();
        kill           = 1'b0;
        sample_valid   = 1'b0;
        frame_ready    = 1'b0;
        check("kill_tx_valid", 32'(tx_valid), 32'd0);
        check("kill_tx_data",  32'(tx_data),  32'd0);
        check("kill_level_a",  32'(dut.level_a), 32'd0);
        check("kill_level_b",  32'(dut.level_b), 32'd0);
        check("kill_underrun", 32'(underrun), 32'd0);
        check("kill_overflow", 32'(overflow), 32'd0);
        frame();
        check("idle_frame_ignored", 32'(underrun), 32'd0);

        // ---------------- asynchronous reset mid-RUN ----------------
        for (int i = 1; i <= 4; i++) write_sample(1'b0, 20'h00400 + 20'(i));
        for (int i = 1; i <= 4; i++) write_sample(1'b1, 20'h00500 + 20'(i));
        tick();
        check_slot("prerst_a", 1'b0, 20'h00401);
        frame();
        check_slot("prerst_b", 1'b1, 20'h00501);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx_valid",   32'(tx_valid),   32'd0);
        check("async_rst_tx_data",    32'(tx_data),    32'd0);
        check("async_rst_tx_channel", 32'(tx_channel), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) write_sample(1'b0, 20'h00600 + 20'(i));
        for (int i = 1; i <= 3; i++) write_sample(1'b1, 20'h00700 + 20'(i));
        tick();
        check("postrst_prefill_low", 32'(tx_valid), 32'd0);
        write_sample(1'b1, 20'h00704);
        tick();
        check_slot("postrst_a", 1'b0, 20'h00601);
        frame();
        check_slot("postrst_b", 1'b1, 20'h00701);

`ifdef SPDIF_SCHED_STATS_EN
        // ---------------- statistics saturation ----------------
        do_kill();
        for (int i = 1; i <= 4; i++) write_sample(1'b0, 20'h00800 + 20'(i));
        for (int i = 1; i <= 4; i++) write_sample(1'b1, 20'h00900 + 20'(i));
        tick();
        repeat (8) frame();
        repeat (300) frame();
        check("stats_underrun_sat", 32'(underrun_cnt), 32'd255);
        do_kill();
        check("stats_kill_keeps", 32'(underrun_cnt), 32'd255);
        #2;
        rst_n = 1'b0;
        #1;
        check("stats_rst_clears", 32'(underrun_cnt), 32'd0);
        check("stats_rst_clears_ovf", 32'(overflow_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_spdif_tx_scheduler

// File: doc/spdif_tx_scheduler.md
SPDIF_TX_SCHEDULER -- requirements
Module: spdif_tx_scheduler

Interface
REQ-001 SHALL have parameter DW, default 20, audio sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, per-channel FIFO depth (power of two, >=4).
REQ-003 SHALL have parameter PREFILL, default 4, samples required in each channel before transmission starts (1..DEPTH).
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 sample_in  in  DW  decoded sample from the frame-dismantle stage.
REQ-007 sample_valid  in  1  single-cycle strobe qualifying sample_in.
REQ-008 sample_channel  in  1  0 = channel A (left), 1 = channel B (right).
REQ-009 kill  in  1  receiver lost lock; flush request.
REQ-010 frame_ready  in  1  single-cycle strobe from frame_assembly consuming tx_data.
REQ-011 tx_data  out  DW  sample presented to frame_assembly.
REQ-012 tx_valid  out  1  drives frame_assembly fifo_ready; high while tx_data is valid.
REQ-013 tx_channel  out  1  channel of tx_data.
REQ-014 underrun  out  1  one-cycle pulse when silence substitutes a sample.
REQ-015 overflow  out  1  one-cycle pulse when an input sample is dropped.

Function
REQ-016 SHALL write sample_in to FIFO A or B per sample_channel on sample_valid.
REQ-017 SHALL drop a write to a full FIFO, keep its contents unchanged, and pulse overflow next cycle.
REQ-018 SHALL implement FSM IDLE -> PREFILL -> RUN_A <-> RUN_B.
REQ-019 IDLE: tx_valid=0; go to PREFILL on the first sample_valid.
REQ-020 PREFILL: tx_valid=0; go to RUN_A when both FIFO levels >= PREFILL.
REQ-021 RUN_A/RUN_B: tx_valid=1, tx_channel=0/1, tx_data = head of FIFO A/B.
REQ-022 On frame_ready in RUN_x: pop FIFO x and move to the other RUN state; the next tx_data is valid one cycle later (latency 1).
REQ-023 If FIFO x is empty in RUN_x: tx_data = 0 (silence), frame_ready pulses underrun, no pop, state still alternates.
REQ-024 frame_ready while tx_valid=0 SHALL be ignored.
REQ-025 Simultaneous write and pop on the same FIFO SHALL both occur; the level stays the same; a full FIFO SHALL accept the write in that case.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; level width = clog2(DEPTH)+1.
REQ-027 kill SHALL synchronously empty both FIFOs and enter IDLE next cycle, with priority over every other event in that cycle.
REQ-028 tx_data SHALL be held stable while tx_valid=1 and no frame_ready is seen.

Reset
REQ-029 Asserting rst_n low SHALL asynchronously force state IDLE, all pointers and levels to 0, and tx_data, tx_valid, tx_channel, underrun and overflow to 0.
REQ-030 Reset deasserted mid-operation SHALL resume from IDLE with no residual FIFO contents.

Configuration
REQ-031 With SPDIF_SCHED_STATS_EN defined, the block SHALL add outputs underrun_cnt[7:0] and overflow_cnt[7:0], saturating at 255, cleared by reset only (not by kill).
REQ-032 Without SPDIF_SCHED_STATS_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-033 The shared package spdif_pkg SHALL hold SAMPLE_W=20, the channel enum (CH_A, CH_B) and the scheduler state enum.
REQ-034 Per-channel storage SHALL be one sub-module, sched_fifo, instantiated twice (synchronous FIFO with level, full and empty outputs, plus a flush input).

Verification
REQ-035 Reset, then 4 A / 4 B samples (A=0x00001..4, B=0x10001..4), then frame_ready every 8 cycles -> tx sequence A1,B1,A2,B2,...; tx_valid rises only after the 4th B write.
REQ-036 9 A writes at DEPTH=8 without pops -> exactly one overflow pulse; the popped data is A1..A8.
REQ-037 After prefill, 3 frame_ready pulses beyond the available B data -> tx_data=0 on each starved B slot, one underrun pulse per starved slot, alternation preserved.
REQ-038 kill asserted in the same cycle as sample_valid and frame_ready -> IDLE, tx_valid=0 and both levels 0 next cycle; the sample is not stored.
REQ-039 rst_n pulsed low mid-RUN between clock edges -> outputs 0 immediately (async); after release, PREFILL must refill before tx_valid rises.
REQ-040 With SPDIF_SCHED_STATS_EN, 300 underruns -> underrun_cnt=255; kill leaves it at 255; rst_n low clears it to 0.
